// File: rtl/spi_minion_pkg.sv
// Shared types and constants for the SPI minion.
package spi_minion_pkg;

  // Number of flops each SPI pin passes through before it is used.
  localparam int SYNC_STAGES = 2;

  // Transaction-level state of the minion.
  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

endpackage

// File: rtl/spi_minion_sync.sv
// Multi-bit pin synchroniser with a previous-value register for edge detection.
// Each bit is independent; rise/fall are single-cycle pulses on the synchronised value.
module spi_minion_sync
  import spi_minion_pkg::*;
#(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] stage [SYNC_STAGES];
  logic [W-1:0] prev;

  // Shift the raw pins through the synchroniser chain and remember the last settled value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
      prev <= stage[SYNC_STAGES-1];
    end
  end

  assign q    = stage[SYNC_STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_minion_val_rdy.sv
// SPI mode-0 minion: oversamples cs/sclk/mosi, assembles MSB-first words onto a
// val/rdy send port and shifts a word taken from the val/rdy recv port out on miso.
//
// Handshake rule for both ports: a transfer happens on a rising clk edge where
// val && rdy are both 1. The producer holds val and msg stable until that edge;
// rdy may change freely and never depends combinationally on val.
module spi_minion_val_rdy
  import spi_minion_pkg::*;
#(
  parameter int nbits = 34
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  input  logic             recv_val,
  output logic             recv_rdy,
  input  logic [nbits-1:0] recv_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic [nbits-1:0] send_msg,
  output logic             overflow
);

  localparam int             CW      = $clog2(nbits + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(nbits);
  localparam logic [1:0]     SETTLE  = 2'(SYNC_STAGES);

  // Pin bit order inside the synchroniser: [2]=cs, [1]=sclk, [0]=mosi.
  logic [2:0] pin_q, pin_rise, pin_fall;

  spi_minion_sync #(
    .W       (3),
    .RST_VAL (3'b100)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({cs, sclk, mosi}),
    .q     (pin_q),
    .rise  (pin_rise),
    .fall  (pin_fall)
  );

  logic cs_sync, mosi_sync, cs_fall, cs_rise, sclk_rise, sclk_fall;
  assign cs_sync   = pin_q[2];
  assign mosi_sync = pin_q[0];
  assign cs_fall   = pin_fall[2];
  assign cs_rise   = pin_rise[2];
  assign sclk_rise = pin_rise[1];
  assign sclk_fall = pin_fall[1];

  // Synchronised sclk level and mosi edges have no consumer.
  logic unused_sync;
  assign unused_sync = &{1'b0, pin_q[1], pin_rise[0], pin_fall[0]};

  state_t           state;
  logic [1:0]       init_cnt;
  logic             tx_full;
  logic [nbits-1:0] tx_data;
  logic [nbits-1:0] tx_shreg;
  logic [nbits-1:0] rx_shreg;
  logic [CW-1:0]    bitcnt;

  logic recv_fire, send_fire;
  assign recv_rdy  = !reset && !tx_full && (state != ACTIVE);
  assign recv_fire = recv_val && recv_rdy;
  assign send_fire = send_val && send_rdy;

  assign miso = (state == ACTIVE) && tx_shreg[nbits-1];

  // Transaction FSM with tx/rx shift registers and the one-entry buffers.
  // INIT waits for the synchroniser to refill with real pin samples before
  // trusting cs, so a reset mid-transaction waits for the master to release cs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
      tx_full  <= 1'b0;
      tx_data  <= '0;
      tx_shreg <= '0;
      rx_shreg <= '0;
      bitcnt   <= '0;
      send_val <= 1'b0;
      send_msg <= '0;
      overflow <= 1'b0;
    end else begin
      if (send_fire) send_val <= 1'b0;

      case (state)
        INIT: begin
          if (init_cnt != SETTLE) init_cnt <= init_cnt + 2'd1;
          else if (cs_sync)       state    <= IDLE;
        end
        IDLE: begin
          if (cs_fall) begin
            state    <= ACTIVE;
            tx_shreg <= tx_full ? tx_data : '0;
            tx_full  <= 1'b0;
            rx_shreg <= '0;
            bitcnt   <= '0;
          end
        end
        ACTIVE: begin
          if (sclk_rise) begin
            rx_shreg <= {rx_shreg[nbits-2:0], mosi_sync};
            if (bitcnt != CNT_MAX) bitcnt <= bitcnt + CW'(1);
          end
          if (sclk_fall) tx_shreg <= {tx_shreg[nbits-2:0], 1'b0};
          if (cs_rise) begin
            state <= IDLE;
            if (bitcnt != '0) begin
              if (!send_val || send_fire) begin
                send_msg <= rx_shreg;
                send_val <= 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end
          end
        end
        default: state <= INIT;
      endcase

      // A word accepted on the same edge as cs_fall is kept for the following transaction.
      if (recv_fire) begin
        tx_data <= recv_msg;
        tx_full <= 1'b1;
      end
    end
  end

endmodule
